alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle combinational ALU in the CPU execute stage.
- Simple ops (ADD/SUB/AND/OR/XOR/NOT) finish in one cycle; MUL and DIV are iterative, one bit per cycle.
- Operands enter and results leave through valid/ready handshakes, so the pipeline stalls on long ops.
- Results are registered. The block produces full flags plus a DIV remainder.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_mc_if.sv | 31 +++
 rtl/alu_muldiv_iter.sv | 86 ++++++++
 rtl/alu_mc.sv | 166 ++++++++++++++++
 tb/tb_alu_mc.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op encodings, FSM states and
// flag bit positions within the 5-bit {DZ, V, C, N, Z} flags vector.
package alu_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned FLAGS_W = 5;

    localparam int unsigned FLAG_Z  = 0;
    localparam int unsigned FLAG_N  = 1;
    localparam int unsigned FLAG_C  = 2;
    localparam int unsigned FLAG_V  = 3;
    localparam int unsigned FLAG_DZ = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mc_if.sv
// Handshake bundle between the execute stage and alu_mc.
//   master: drives in_valid/op/a/b and out_ready, observes in_ready and results.
//   slave : the ALU side.
interface alu_mc_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 3
);
    import alu_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [OPW-1:0]     op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   rem;
    logic [FLAGS_W-1:0] flags;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, rem, flags
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, rem, flags
    );

endinterface

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle engine shared by MUL (shift-add) and DIV (restoring).
// start loads the operands; iterations then run on the following WIDTH edges.
// done_c is high in the cycle whose closing edge performs the last iteration,
// so the caller captures hi_nxt_c/lo_nxt_c on that edge.
//   MUL: {hi,lo} ends as the 2*WIDTH product (lo = low half).
//   DIV: lo ends as the quotient, hi as the remainder.
// Ports: clk, rst (async, active-high), start, is_div, a, b -> done_c,
//        hi_nxt_c, lo_nxt_c.
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_c,
    output logic [WIDTH-1:0] hi_nxt_c,
    output logic [WIDTH-1:0] lo_nxt_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic             active_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH:0]   shift_c;
    logic [WIDTH:0]   step_c;

    assign done_c = active_q && (cnt_q == CNT_W'(WIDTH - 1));

    // Single iteration of the selected algorithm.
    always_comb begin
        shift_c  = {hi_q, lo_q[WIDTH-1]};
        step_c   = '0;
        hi_nxt_c = hi_q;
        lo_nxt_c = lo_q;
        if (div_q) begin
            // Trial subtract; a clear top bit means the divisor fit.
            step_c = shift_c - {1'b0, opb_q};
            if (!step_c[WIDTH]) begin
                hi_nxt_c = step_c[WIDTH-1:0];
                lo_nxt_c = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt_c = shift_c[WIDTH-1:0];
                lo_nxt_c = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Add multiplicand when the current multiplier bit is set, then shift right.
            step_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
            hi_nxt_c = step_c[WIDTH:1];
            lo_nxt_c = {step_c[0], lo_q[WIDTH-1:1]};
        end
    end

    // Operand load and iteration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            div_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            div_q    <= is_div;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= is_div ? a : b;
            opb_q    <= is_div ? b : a;
        end else if (active_q) begin
            hi_q  <= hi_nxt_c;
            lo_q  <= lo_nxt_c;
            cnt_q <= cnt_q + 1'b1;
            if (done_c) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Simple ops and DIV-by-zero complete with latency 1; MUL/DIV iterate for
// WIDTH cycles in alu_muldiv_iter. Result, rem and flags are registered and
// held in DONE until the consumer takes them.
// Ports: clk, rst (async, active-high), bus (alu_mc_if.slave).
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 3
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);

    alu_state_e         state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [FLAGS_W-1:0] flags_q, flags_d;
    logic               div_busy_q, div_busy_d;

    alu_op_e            op_c;
    logic               in_ready_c;
    logic               accept_c;
    logic               iter_op_c;
    logic               iter_start_c;
    logic               iter_done_c;
    logic [WIDTH-1:0]   iter_hi_c;
    logic [WIDTH-1:0]   iter_lo_c;

    logic [WIDTH:0]     sum_c;
    logic [WIDTH:0]     dif_c;
    logic [WIDTH-1:0]   sres_c;
    logic [WIDTH-1:0]   srem_c;
    logic [FLAGS_W-1:0] sflg_c;

    assign op_c       = alu_op_e'(OP_W'(bus.op));
    assign in_ready_c = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;
    // DIV by zero bypasses the iterator and finishes like a simple op.
    assign iter_op_c  = (op_c == OP_MUL) || ((op_c == OP_DIV) && (bus.b != '0));

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.rem       = rem_q;
    assign bus.flags     = flags_q;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (iter_start_c),
        .is_div   (op_c == OP_DIV),
        .a        (bus.a),
        .b        (bus.b),
        .done_c   (iter_done_c),
        .hi_nxt_c (iter_hi_c),
        .lo_nxt_c (iter_lo_c)
    );

    // Single-cycle datapath and its flags.
    always_comb begin
        sum_c  = {1'b0, bus.a} + {1'b0, bus.b};
        dif_c  = {1'b0, bus.a} - {1'b0, bus.b};
        sres_c = '0;
        srem_c = '0;
        sflg_c = '0;
        case (op_c)
            OP_ADD: begin
                sres_c         = sum_c[WIDTH-1:0];
                sflg_c[FLAG_C] = sum_c[WIDTH];
                sflg_c[FLAG_V] = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                                 (sum_c[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sres_c         = dif_c[WIDTH-1:0];
                sflg_c[FLAG_C] = dif_c[WIDTH];
                sflg_c[FLAG_V] = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                                 (dif_c[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_DIV: begin
                sres_c          = '1;
                srem_c          = bus.a;
                sflg_c[FLAG_DZ] = 1'b1;
            end
            OP_AND:  sres_c = bus.a & bus.b;
            OP_OR:   sres_c = bus.a | bus.b;
            OP_XOR:  sres_c = bus.a ^ bus.b;
            OP_NOT:  sres_c = ~bus.a;
            default: sres_c = '0;
        endcase
        sflg_c[FLAG_Z] = (sres_c == '0);
        sflg_c[FLAG_N] = sres_c[WIDTH-1];
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        result_d     = result_q;
        rem_d        = rem_q;
        flags_d      = flags_q;
        div_busy_d   = div_busy_q;
        iter_start_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if ((state_q == ST_DONE) && bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
                if (accept_c) begin
                    if (iter_op_c) begin
                        iter_start_c = 1'b1;
                        div_busy_d   = (op_c == OP_DIV);
                        state_d      = ST_BUSY;
                        out_valid_d  = 1'b0;
                    end else begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        result_d    = sres_c;
                        rem_d       = srem_c;
                        flags_d     = sflg_c;
                    end
                end
            end
            ST_BUSY: begin
                if (iter_done_c) begin
                    state_d         = ST_DONE;
                    out_valid_d     = 1'b1;
                    result_d        = iter_lo_c;
                    rem_d           = div_busy_q ? iter_hi_c : '0;
                    flags_d         = '0;
                    flags_d[FLAG_Z] = (iter_lo_c == '0);
                    flags_d[FLAG_N] = iter_lo_c[WIDTH-1];
                    flags_d[FLAG_V] = !div_busy_q && (iter_hi_c != '0);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rem_q       <= '0;
            flags_q     <= '0;
            div_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            rem_q       <= rem_d;
            flags_q     <= flags_d;
            div_busy_q  <= div_busy_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_mc_if #(.WIDTH(W), .OPW(3)) bus ();

    alu_mc #(.WIDTH(W), .OPW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op and hold it until accepted on an edge.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    // Latency counted from the accept edge; also counts cycles with in_ready low.
    task automatic wait_out(input int max, output int lat, output int rdy_low);
        lat     = 1;
        rdy_low = 0;
        while (!bus.out_valid && lat <= max) begin
            if (!bus.in_ready) rdy_low++;
            step();
            lat++;
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] res,
                             input logic [31:0] rm, input logic [4:0] flg);
        chk({tag, "_res"},   64'(bus.result), 64'(res));
        chk({tag, "_rem"},   64'(bus.rem),    64'(rm));
        chk({tag, "_flags"}, 64'(bus.flags),  64'(flg));
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int rl;
        logic [2:0]  b2b_op  [4];
        logic [31:0] b2b_exp [4];

        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check_out("rst", 32'h0, 32'h0, 5'b00000);

        // ADD overflow, SUB zero, SUB borrow
        send(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        wait_out(5, lat, rl);
        chk("add_lat", 64'(lat), 64'd1);
        check_out("add_ovf", 32'h8000_0000, 32'h0, 5'b01010);
        consume();

        send(OP_SUB, 32'd5, 32'd5);
        wait_out(5, lat, rl);
        chk("sub_lat", 64'(lat), 64'd1);
        check_out("sub_zero", 32'h0, 32'h0, 5'b00001);
        consume();

        send(OP_SUB, 32'd3, 32'd5);
        wait_out(5, lat, rl);
        check_out("sub_borrow", 32'hFFFF_FFFE, 32'h0, 5'b00110);
        consume();

        // MUL with product overflowing into the upper half
        send(OP_MUL, 32'h0001_0000, 32'h0001_0000);
        wait_out(50, lat, rl);
        chk("mul_lat",     64'(lat), 64'd33);
        chk("mul_rdy_low", 64'(rl),  64'd32);
        check_out("mul_ovf", 32'h0, 32'h0, 5'b01001);
        consume();

        send(OP_MUL, 32'd12345, 32'd678);
        wait_out(50, lat, rl);
        chk("mul2_lat", 64'(lat), 64'd33);
        check_out("mul2", 32'h007F_B6F6, 32'h0, 5'b00000);
        consume();

        // DIV normal and divide-by-zero
        send(OP_DIV, 32'd100, 32'd7);
        wait_out(50, lat, rl);
        chk("div_lat", 64'(lat), 64'd33);
        check_out("div", 32'd14, 32'd2, 5'b00000);
        consume();

        send(OP_DIV, 32'd9, 32'd0);
        wait_out(50, lat, rl);
        chk("divz_lat", 64'(lat), 64'd1);
        check_out("divz", 32'hFFFF_FFFF, 32'd9, 5'b10010);
        consume();

        // Back-to-back logic ops, one result per cycle
        b2b_op[0]  = OP_AND; b2b_exp[0] = 32'h000F_000F;
        b2b_op[1]  = OP_OR;  b2b_exp[1] = 32'h0FFF_0FFF;
        b2b_op[2]  = OP_XOR; b2b_exp[2] = 32'h0FF0_0FF0;
        b2b_op[3]  = OP_NOT; b2b_exp[3] = 32'hF0F0_F0F0;
        bus.out_ready = 1'b1;
        bus.a         = 32'h0F0F_0F0F;
        bus.b         = 32'h00FF_00FF;
        for (int i = 0; i < 4; i++) begin
            bus.op       = b2b_op[i];
            bus.in_valid = 1'b1;
            step();
            chk($sformatf("b2b%0d_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("b2b%0d_res", i),   64'(bus.result),    64'(b2b_exp[i]));
        end
        bus.in_valid = 1'b0;
        step();
        chk("b2b_drain_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;

        // Backpressure holds outputs and blocks new ops
        send(OP_ADD, 32'd3, 32'd4);
        wait_out(5, lat, rl);
        chk("bp_lat", 64'(lat), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("bp%0d_res", i),   64'(bus.result),    64'd7);
            chk($sformatf("bp%0d_flags", i), 64'(bus.flags),     64'd0);
            chk($sformatf("bp%0d_ready", i), 64'(bus.in_ready),  64'd0);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.out_ready = 1'b0;
        chk("bp_release_valid", 64'(bus.out_valid), 64'd0);

        // Async reset in the middle of a DIV
        send(OP_DIV, 32'd100, 32'd7);
        repeat (9) step();
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_ready", 64'(bus.in_ready),  64'd1);
        check_out("abort", 32'h0, 32'h0, 5'b00000);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(bus.in_ready),  64'd1);
        chk("post_rst_valid", 64'(bus.out_valid), 64'd0);

        send(OP_ADD, 32'd1, 32'd1);
        wait_out(5, lat, rl);
        chk("post_add_lat", 64'(lat), 64'd1);
        check_out("post_add", 32'd2, 32'h0, 5'b00000);
        consume();

        send(OP_DIV, 32'd9, 32'd3);
        wait_out(50, lat, rl);
        chk("post_div_lat", 64'(lat), 64'd33);
        check_out("post_div", 32'd3, 32'd0, 5'b00000);
        consume();

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
